pipe_ctrl: RTL

- Pipeline control unit for the five-stage Y86-64 pipeline (F, D, E, M, W).
- Detects load/use, ret and mispredicted-branch hazards. Drives per-stage stall/bubble controls and the condition-code write enable.
- Runs the processor run-state FSM (IDLE, RUN, DRAIN, STOPPED) and latches the final status.
- Keeps cycle, retired-instruction and hazard-stall counters for the testbench monitor.

---
 rtl/y86_pkg.sv | 51 +++++
 rtl/pipe_ctrl_sat_counter.sv | 29 ++
 rtl/pipe_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings used by the fetch, decode and pipeline control logic.
// Icodes, status codes, the "no register" ID and the run-state FSM encoding
// live here so every stage agrees on the same values.
package y86_pkg;

  // Instruction codes
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_POPQ   = 4'hB;

  // Register ID meaning "no register"
  localparam logic [3:0] RNONE = 4'hF;

  // Processor status (one-hot)
  localparam logic [2:0] S_AOK = 3'b001;
  localparam logic [2:0] S_HLT = 3'b010;
  localparam logic [2:0] S_ERR = 3'b100;

  // Run-state FSM encoding; kept as plain constants so older blocks that
  // compare raw 2-bit values keep working.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_DRAIN   = 2'd2;
  localparam logic [1:0] ST_STOPPED = 2'd3;

  // Per-stage pipeline register controls produced by the control unit
  typedef struct packed {
    logic f_stall;
    logic d_stall;
    logic d_bubble;
    logic e_bubble;
    logic m_bubble;
    logic w_stall;
    logic set_cc;
  } ctrl_t;

  // Instructions whose result comes from memory and arrives too late to forward
  function automatic logic is_mem_load(input logic [3:0] icode);
    return (icode == I_MRMOVQ) || (icode == I_POPQ);
  endfunction

  // True while the processor is executing instructions
  function automatic logic is_active(input logic [1:0] st);
    return (st == ST_RUN) || (st == ST_DRAIN);
  endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter for the performance monitor.
// Counts when enabled and sticks at all-ones instead of wrapping, so a long
// run never reports a misleadingly small value.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count
);

  logic at_max;

  // Saturation detect: all bits set means no further increment
  always_comb begin
    at_max = &count;
  end

  // Count register with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en && !at_max) begin
      count <= count + {{(W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control unit for the five-stage Y86-64 pipeline.
// Detects load/use, ret and mispredicted-branch hazards and turns them into
// per-stage stall/bubble controls, runs the processor run-state FSM, latches
// the final status and keeps three saturating performance counters.
module pipe_ctrl
  import y86_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_dstM,
  input  logic             e_cnd,
  input  logic [3:0]       M_icode,
  input  logic [2:0]       m_stat,
  input  logic [3:0]       W_icode,
  input  logic [2:0]       W_stat,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_stall,
  output logic             set_cc,
  output logic [1:0]       run_state,
  output logic [2:0]       stat_out,
  output logic [CNT_W-1:0] cyc_count,
  output logic [CNT_W-1:0] ret_count,
  output logic [CNT_W-1:0] stl_count
);

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic [2:0] stat_q;

  logic loaduse;
  logic retp;
  logic mispred;
  logic exc_m;
  logic exc_w;
  logic active;

  ctrl_t ctrl;

  logic cyc_en;
  logic ret_en;
  logic stl_en;

  // Hazard detection from the current pipeline register contents
  always_comb begin
    loaduse = is_mem_load(E_icode) && (E_dstM != RNONE) &&
              ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    retp    = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
    mispred = (E_icode == I_JXX) && !e_cnd;
    exc_m   = (m_stat != S_AOK);
    exc_w   = (W_stat != S_AOK);
    active  = is_active(state_q);
  end

  // Stage controls: hazard-driven while executing, fixed while idle or stopped.
  // loaduse wins over the ret bubble in D so D is never held and bubbled at once.
  always_comb begin
    ctrl = '0;
    case (state_q)
      ST_RUN, ST_DRAIN: begin
        ctrl.f_stall  = loaduse | retp;
        ctrl.d_stall  = loaduse;
        ctrl.d_bubble = mispred | (retp & !loaduse);
        ctrl.e_bubble = mispred | loaduse;
        ctrl.m_bubble = exc_m | exc_w;
        ctrl.w_stall  = exc_w;
        ctrl.set_cc   = (E_icode == I_OPQ) & !exc_m & !exc_w;
      end
      ST_STOPPED: begin
        ctrl.f_stall  = 1'b1;
        ctrl.d_stall  = 1'b1;
        ctrl.d_bubble = 1'b0;
        ctrl.e_bubble = 1'b1;
        ctrl.m_bubble = 1'b1;
        ctrl.w_stall  = 1'b1;
        ctrl.set_cc   = 1'b0;
      end
      default: begin
        ctrl.f_stall  = 1'b1;
        ctrl.d_bubble = 1'b1;
        ctrl.e_bubble = 1'b1;
        ctrl.m_bubble = 1'b1;
      end
    endcase
  end

  // Drive the stage control ports from the control bundle
  always_comb begin
    F_stall  = ctrl.f_stall;
    D_stall  = ctrl.d_stall;
    D_bubble = ctrl.d_bubble;
    E_bubble = ctrl.e_bubble;
    M_bubble = ctrl.m_bubble;
    W_stall  = ctrl.w_stall;
    set_cc   = ctrl.set_cc;
  end

  // Run-state next-state logic; a writeback exception always ends the run,
  // a memory exception only parks the machine in DRAIN until it resolves
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (exc_w)      state_d = ST_STOPPED;
        else if (exc_m) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (exc_w)       state_d = ST_STOPPED;
        else if (!exc_m) state_d = ST_RUN;
      end
      default: state_d = ST_STOPPED;
    endcase
  end

  // Run-state and final-status registers; status is captured on entry to STOPPED
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      stat_q  <= S_AOK;
    end else begin
      state_q <= state_d;
      if (active && exc_w) begin
        stat_q <= W_stat;
      end
    end
  end

  // Counter enables: all counting is confined to the executing states
  always_comb begin
    cyc_en = active;
    ret_en = active && (W_stat == S_AOK) && (W_icode != I_NOP) && !ctrl.w_stall;
    stl_en = active && ctrl.f_stall;
  end

  sat_counter #(.W(CNT_W)) u_cyc_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (cyc_en),
    .count (cyc_count)
  );

  sat_counter #(.W(CNT_W)) u_ret_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ret_en),
    .count (ret_count)
  );

  sat_counter #(.W(CNT_W)) u_stl_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (stl_en),
    .count (stl_count)
  );

  assign run_state = state_q;
  assign stat_out  = stat_q;

endmodule
